prbs7_checker: RTL and testbench

- Serial receive-side checker for the 7-bit PRBS stream produced by the team's LFSR generator.
- Sequence obeys b(t) = b(t-1) XOR b(t-7), i.e. polynomial x^7+x^6+1, period 127.
- Self-synchronises to the incoming bit stream, declares lock, then flags and counts bit errors; drops lock on excessive errors or a dead (all-zero) line.
- Sits at the far end of a link or loopback, fed one bit per valid cycle from the generator's serial output (y[6]).

---
 rtl/prbs7_checker.sv | 153 +++++++++++++++
 tb/tb_prbs7_checker.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs7_checker.sv
// Receive-side checker for the x^7+x^6+1 PRBS stream: hunts, syncs, locks, then flags bit errors.
// Define PRBS_ERRCNT_EN to build the saturating err_cnt counter; otherwise err_cnt reads zero.
module prbs7_checker #(
    parameter int LOCK_CNT  = 16,
    parameter int ERR_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_vld,
    input  logic        din,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_cnt,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] s_q, s_d;
    logic [2:0] fill_q, fill_d;
    logic [6:0] match_q, match_d;
    logic [6:0] win_q, win_d;
    logic [6:0] werr_q, werr_d;
    logic       locked_q, locked_d;
    logic       err_q, err_d;

    logic       exp_bit;
    logic       mismatch;
    logic [6:0] s_shift;
    logic [6:0] match_inc;
    logic [6:0] werr_base;

    always_comb begin
        exp_bit   = s_q[0] ^ s_q[6];
        mismatch  = din_vld & (din != exp_bit);
        s_shift   = {s_q[5:0], din};
        match_inc = match_q + 7'd1;
        werr_base = werr_q;

        state_d = state_q;
        s_d     = s_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        err_d   = 1'b0;

        if (din_vld) begin
            // The register tracks what was received, so a bit error echoes into later predictions.
            s_d = s_shift;
            unique case (state_q)
                HUNT: begin
                    if (fill_q == 3'd6) begin
                        state_d = SYNC;
                        fill_d  = 3'd0;
                        match_d = 7'd0;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
                SYNC: begin
                    if (mismatch || (s_q == 7'd0)) begin
                        match_d = 7'd0;
                    end else begin
                        match_d = match_inc;
                        if (match_inc == 7'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            win_d   = 7'd0;
                            werr_d  = 7'd0;
                        end
                    end
                end
                LOCKED: begin
                    err_d = mismatch;
                    if (win_q == 7'd126) begin
                        win_d     = 7'd0;
                        werr_base = 7'd0;
                    end else begin
                        win_d = win_q + 7'd1;
                    end
                    werr_d = werr_base + {6'd0, mismatch};
                    if ((werr_d == 7'(ERR_LIMIT)) || (s_shift == 7'd0)) begin
                        state_d = HUNT;
                        fill_d  = 3'd0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            s_q      <= 7'd0;
            fill_q   <= 3'd0;
            match_q  <= 7'd0;
            win_q    <= 7'd0;
            werr_q   <= 7'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            win_q    <= win_d;
            werr_q   <= werr_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

`ifdef PRBS_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // A clear in the same cycle as an error wins; that error is not counted.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = 16'h0000;
        end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 16'h0000;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign err_cnt        = 16'h0000;
`endif

    assign locked = locked_q;
    assign err    = err_q;
    assign state  = state_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Self-checking bench for prbs7_checker: randomized PRBS traffic against a history-queue reference model.
`timescale 1ns/1ps
module tb_prbs7_checker;
    localparam int LOCK_CNT  = 16;
    localparam int ERR_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst, din_vld, din, clr_cnt;
    logic        locked, err;
    logic [15:0] err_cnt;
    logic [1:0]  state;

    logic        s_rst, s_vld, s_din, s_clr;
    logic        s_locked, s_err;
    logic [15:0] s_err_cnt;
    logic [1:0]  s_state;

    int checks = 0;
    int errors = 0;

    bit prbs [127];
    int sp;

    bit hist [$];
    int m_state, m_fill, m_match, m_win, m_werr, m_errcnt;
    bit m_err;

    prbs7_checker #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_cnt(err_cnt), .state(state)
    );

    prbs7_checker #(.LOCK_CNT(16), .ERR_LIMIT(127)) dut_sat (
        .clk(clk), .rst(s_rst), .din_vld(s_vld), .din(s_din), .clr_cnt(s_clr),
        .locked(s_locked), .err(s_err), .err_cnt(s_err_cnt), .state(s_state)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int hist_ones();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i]);
        return n;
    endfunction

    function automatic logic [19:0] exp_vec();
        return {2'(m_state), (m_state == 2), m_err, 16'(m_errcnt)};
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 7; i++) hist.push_back(1'b0);
        m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        m_err = 1'b0; m_errcnt = 0;
    endtask

    // hist[0] is the bit seen 7 valid cycles ago, hist[6] the most recent one.
    task automatic model_step(input bit v, input bit d, input bit c);
        bit pred, mis, zero_pre, zero_post;
        m_err = 1'b0;
        if (v) begin
            pred     = hist[6] ^ hist[0];
            mis      = (d != pred);
            zero_pre = (hist_ones() == 0);
            hist.push_back(d);
            hist.delete(0);
            zero_post = (hist_ones() == 0);
            case (m_state)
                0: begin
                    m_fill++;
                    if (m_fill == 7) begin m_state = 1; m_fill = 0; m_match = 0; end
                end
                1: begin
                    if (mis || zero_pre) m_match = 0;
                    else begin
                        m_match++;
                        if (m_match == LOCK_CNT) begin m_state = 2; m_win = 0; m_werr = 0; end
                    end
                end
                default: begin
                    m_err = mis;
                    if (m_win == 126) begin m_win = 0; m_werr = 0; end
                    else m_win++;
                    if (mis) m_werr++;
                    if (m_werr == ERR_LIMIT || zero_post) begin m_state = 0; m_fill = 0; end
                end
            endcase
        end
`ifdef PRBS_ERRCNT_EN
        if (c) m_errcnt = 0;
        else if (m_err && m_errcnt < 65535) m_errcnt++;
`endif
    endtask

    task automatic tick(input bit v, input bit d, input bit c);
        din_vld = v; din = d; clr_cnt = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
    endtask

    task automatic stream_bit(output bit b);
        b = prbs[sp % 127];
        sp++;
    endtask

    task automatic do_reset();
        rst = 1'b1; din_vld = 1'($urandom); din = 1'($urandom); clr_cnt = 1'($urandom);
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0; sp = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (err_cnt !== 16'h0000) begin errors++; $display("FAIL reset_err_cnt: got %h expected 0000", err_cnt); end
    endtask

    task automatic test_lock();
        bit b;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            stream_bit(b);
            tick(1'b1, b, 1'b0);
            if (err) pulses++;
            checks++;
            if ({state, locked, err, err_cnt} !== exp_vec()) begin
                errors++;
                $display("FAIL lock_seq bit %0d: got %h expected %h", i, {state, locked, err, err_cnt}, exp_vec());
            end
            if (i == 6) begin
                checks++; if (state !== 2'b01) begin errors++; $display("FAIL lock_sync_entry: got %b expected 01", state); end
            end
            if (i == 21) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", locked); end
            end
            if (i == 22) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_time: got %b expected 1", locked); end
            end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL lock_clean_errs: got %0d expected 0", pulses); end
    endtask

    task automatic test_single_error();
        bit b;
        int pulses = 0, m_pulses = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stream_bit(b);
            tick(1'b1, b ^ (i == 200), 1'b0);
            if (err) pulses++;
            if (m_err) m_pulses++;
            checks++;
            if ({state, locked, err, err_cnt} !== exp_vec()) begin
                errors++;
                $display("FAIL single_err bit %0d: got %h expected %h", i, {state, locked, err, err_cnt}, exp_vec());
            end
            if (i == 200) begin
                checks++; if (err !== 1'b1) begin errors++; $display("FAIL single_err_pulse: got %b expected 1", err); end
            end
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_err_locked: got %b expected 1", locked); end
        checks++; if (pulses != m_pulses) begin errors++; $display("FAIL single_err_count: got %0d expected %0d", pulses, m_pulses); end
    endtask

    task automatic test_err_limit();
        bit b;
        bit dropped = 1'b0;
        int idx = 0;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            int gap = (k == 0) ? 30 : int'($urandom_range(7, 11));
            for (int g = 0; g <= gap; g++) begin
                stream_bit(b);
                tick(1'b1, b ^ (k > 0 && g == gap), 1'b0);
                idx++;
                if (!locked && idx > 23) dropped = 1'b1;
                checks++;
                if ({state, locked, err, err_cnt} !== exp_vec()) begin
                    errors++;
                    $display("FAIL err_limit bit %0d: got %h expected %h", idx, {state, locked, err, err_cnt}, exp_vec());
                end
            end
        end
        checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL err_limit_drop: got %b expected 1", dropped); end
        for (int i = 0; i < 80; i++) begin
            stream_bit(b);
            tick(1'b1, b, 1'b0);
            checks++;
            if ({state, locked, err, err_cnt} !== exp_vec()) begin
                errors++;
                $display("FAIL err_limit_relock bit %0d: got %h expected %h", i, {state, locked, err, err_cnt}, exp_vec());
            end
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err_limit_relocked: got %b expected 1", locked); end
    endtask

    task automatic test_zero_line();
        bit b;
        bit bad = 1'b0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0 || err !== 1'b0 || state === 2'b10) bad = 1'b1;
            checks++;
            if ({state, locked, err, err_cnt} !== exp_vec()) begin
                errors++;
                $display("FAIL zero_line bit %0d: got %h expected %h", i, {state, locked, err, err_cnt}, exp_vec());
            end
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL zero_line_no_lock: got %b expected 0", bad); end
        sp = 0;
        for (int i = 0; i < 23; i++) begin
            stream_bit(b);
            tick(1'b1, b, 1'b0);
            checks++;
            if ({state, locked, err, err_cnt} !== exp_vec()) begin
                errors++;
                $display("FAIL zero_to_stream bit %0d: got %h expected %h", i, {state, locked, err, err_cnt}, exp_vec());
            end
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL zero_to_stream_lock: got %b expected 1", locked); end
    endtask

    task automatic test_vld_gap();
        bit b;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin stream_bit(b); tick(1'b1, b, 1'b0); end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'($urandom), 1'b0);
            checks++;
            if ({state, locked, err} !== 4'b1010) begin
                errors++;
                $display("FAIL vld_gap_hold cycle %0d: got %b expected 1010", i, {state, locked, err});
            end
        end
        for (int i = 0; i < 150; i++) begin
            stream_bit(b);
            tick(1'b1, b, 1'b0);
            if (err) pulses++;
            checks++;
            if ({state, locked, err, err_cnt} !== exp_vec()) begin
                errors++;
                $display("FAIL vld_gap_resume bit %0d: got %h expected %h", i, {state, locked, err, err_cnt}, exp_vec());
            end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL vld_gap_errs: got %0d expected 0", pulses); end
    endtask

    task automatic test_clr_cnt();
        bit b;
        do_reset();
        for (int i = 0; i < 40; i++) begin stream_bit(b); tick(1'b1, b, 1'b0); end
        stream_bit(b);
        tick(1'b1, ~b, 1'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_cnt_err: got %b expected 1", err); end
        checks++; if (err_cnt !== 16'h0000) begin errors++; $display("FAIL clr_cnt_priority: got %h expected 0000", err_cnt); end
        for (int i = 0; i < 10; i++) begin
            stream_bit(b);
            tick(1'b1, b, 1'b0);
            checks++;
            if ({state, locked, err, err_cnt} !== exp_vec()) begin
                errors++;
                $display("FAIL clr_cnt_after bit %0d: got %h expected %h", i, {state, locked, err, err_cnt}, exp_vec());
            end
        end
        tick(1'b0, 1'b0, 1'b1);
        checks++; if (err_cnt !== 16'h0000) begin errors++; $display("FAIL clr_cnt_idle: got %h expected 0000", err_cnt); end
    endtask

    task automatic test_rst_locked();
        bit b;
        do_reset();
        for (int i = 0; i < 40; i++) begin stream_bit(b); tick(1'b1, b, 1'b0); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rst_pre_lock: got %b expected 1", locked); end
        stream_bit(b);
        rst = 1'b1; din_vld = 1'b1; din = ~b; clr_cnt = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        checks++; if ({state, locked, err} !== 4'b0000) begin errors++; $display("FAIL rst_locked: got %b expected 0000", {state, locked, err}); end
    endtask

    task automatic test_random();
        bit b;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit v = ($urandom_range(0, 3) != 0);
            bit inj = ($urandom_range(0, 63) == 0);
            bit c = ($urandom_range(0, 49) == 0);
            if (v) stream_bit(b); else b = 1'($urandom);
            tick(v, b ^ inj, c);
            checks++;
            if ({state, locked, err, err_cnt} !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", i, {state, locked, err, err_cnt}, exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        bit sh [$];
        bit d, pred;
        int nerr = 0, pulses = 0, target, zeros;
        logic [15:0] want_mid, want_end;
`ifdef PRBS_ERRCNT_EN
        target = 65534; want_mid = 16'hFFFE; want_end = 16'hFFFF;
`else
        target = 300; want_mid = 16'h0000; want_end = 16'h0000;
`endif
        for (int i = 0; i < 7; i++) sh.push_back(1'b0);
        s_rst = 1'b1; s_vld = 1'b0; s_din = 1'b0; s_clr = 1'b0;
        @(posedge clk); #1;
        s_rst = 1'b0;
        for (int i = 0; i < 23; i++) begin
            s_vld = 1'b1; s_din = prbs[i];
            @(posedge clk); #1;
            sh.push_back(prbs[i]); sh.delete(0);
        end
        checks++; if (s_locked !== 1'b1) begin errors++; $display("FAIL sat_lock: got %b expected 1", s_locked); end
        for (int i = 0; i < 70000 && nerr < target + 3; i++) begin
            pred = sh[6] ^ sh[0];
            d = ~pred;
            zeros = 0;
            for (int k = 1; k < 7; k++) zeros += int'(!sh[k]);
            if (d == 1'b0 && zeros == 6) d = 1'b1;
            if (d != pred) nerr++;
            s_vld = 1'b1; s_din = d;
            @(posedge clk); #1;
            if (s_err) pulses++;
            sh.push_back(d); sh.delete(0);
            if (nerr == target && d != pred) begin
                checks++;
                if (s_err_cnt !== want_mid) begin errors++; $display("FAIL sat_mid: got %h expected %h", s_err_cnt, want_mid); end
            end
        end
        s_vld = 1'b0;
        checks++; if (nerr != target + 3) begin errors++; $display("FAIL sat_budget: got %0d errors expected %0d", nerr, target + 3); end
        checks++; if (s_err_cnt !== want_end) begin errors++; $display("FAIL sat_end: got %h expected %h", s_err_cnt, want_end); end
        checks++; if (pulses != nerr) begin errors++; $display("FAIL sat_pulses: got %0d expected %0d", pulses, nerr); end
        checks++; if (s_state !== 2'b10) begin errors++; $display("FAIL sat_state: got %b expected 10", s_state); end
    endtask

    initial begin
        rst = 1'b1; din_vld = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        s_rst = 1'b1; s_vld = 1'b0; s_din = 1'b0; s_clr = 1'b0;
        for (int i = 0; i < 7; i++) prbs[i] = 1'b1;
        for (int i = 7; i < 127; i++) prbs[i] = prbs[i-1] ^ prbs[i-7];
        sp = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lock();
        test_single_error();
        test_err_limit();
        test_zero_line();
        test_vld_gap();
        test_clr_cnt();
        test_rst_locked();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
